// File: rtl/arb_mux_n.sv
// arb_mux_n: registered N-to-1 valid/ready mux with direct-select and round-robin modes
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int N = 16,
  parameter int SEL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel,
  output logic [SEL_W-1:0]   rr_ptr
);
  localparam int P = 2**SEL_W;
  logic [P-1:0] valid_x;
  logic [SEL_W-1:0] rr_idx, chosen;
  logic rr_grant, grant, take;
  int j;
  assign valid_x = P'(in_valid);
  // first requester at or after rr_ptr, wrapping modulo N
  always_comb begin
    rr_grant = 1'b0;
    rr_idx = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (in_valid[j]) begin
        rr_grant = 1'b1;
        rr_idx = SEL_W'(j);
      end
    end
  end
  assign chosen = mode ? rr_idx : sel;
  assign grant = mode ? rr_grant : (int'(sel) < N) && valid_x[sel];
  assign take = grant && (!out_valid || out_ready) && !reset;
  assign in_ready = take ? N'(1) << chosen : '0;
  // output slot and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      out_sel <= '0;
      out_valid <= 1'b0;
      rr_ptr <= '0;
    end else if (take) begin
      out_data <= in_data[int'(chosen)*WIDTH +: WIDTH];
      out_sel <= chosen;
      out_valid <= 1'b1;
      if (mode) rr_ptr <= (int'(chosen) == N - 1) ? '0 : chosen + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
Parametrised, registered N-to-1 data multiplexer with a valid/ready handshake on every input channel and on the output. It generalises the fixed 16x1 32-bit combinational select. The block operates in one of two modes:
- Direct mode: the channel is chosen by an external select.
- Round-robin mode: the block arbitrates among requesting channels.

It sits between multiple producers (register-file read ports, memory/IO sources) and a single consumer in the datapath.

Parameters:
WIDTH, 32, data width of each channel in bits
N, 16, number of input channels (2..16, need not be a power of 2)
SEL_W, 4, select/pointer width; must satisfy 2**SEL_W >= N

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  channel i has data to offer
in_ready  output  N  channel i data accepted this cycle (combinational)
mode  input  1  0 = direct select, 1 = round-robin
sel  input  SEL_W  channel index used in direct mode
out_data  output  WIDTH  registered selected data
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data this cycle
out_sel  output  SEL_W  index of the channel that produced out_data
rr_ptr  output  SEL_W  current round-robin search start index (debug/observability)

Behaviour:
- Reset (async, reset=1): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready=0 while reset is asserted. Any word held in the output register is discarded.

Output slot:
- Single-entry output register.
- slot_free = !out_valid || out_ready (combinational).

Channel choice (combinational, each cycle):
- Direct mode:
  - chosen = sel.
  - grant exists iff sel < N and in_valid[sel]=1.
  - sel >= N means no grant and all in_ready=0. This is not an error.
- Round-robin mode:
  - chosen = first index i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1 (modulo N, not modulo 2**SEL_W).
  - grant exists iff any in_valid bit is set.

Acceptance:
- in_ready[chosen] = grant && slot_free. All other in_ready bits are 0.
- At most one in_ready bit is high in any cycle.

Register update on the rising edge:
- If grant && slot_free: out_data <= in_data[chosen], out_sel <= chosen, out_valid <= 1.
- Else if out_ready: out_valid <= 0. out_data and out_sel hold their values.
- Else: all hold.

Round-robin pointer:
- On an accepted transfer in round-robin mode: rr_ptr <= (chosen == N-1) ? 0 : chosen+1.
- rr_ptr is unchanged by direct-mode transfers.
- rr_ptr is retained across mode switches.

Timing and throughput:
- Latency is 1 cycle from acceptance to out_valid.
- Throughput is 1 word/cycle when out_ready is held high.
- Simultaneous out_ready=1 with a new grant: the old word is consumed and the new word is loaded in the same edge, so out_valid stays 1.

Backpressure and stability:
- out_valid=1 with out_ready=0: out_data and out_sel are stable, all in_ready=0, and rr_ptr does not advance.
- mode and sel are sampled each cycle. A change affects only the next arbitration and never a word already held.

Test Plan:
1. Direct mode, N=16, sel=5, in_valid=16'h0020, ch5=32'hDEAD_BEEF, out_ready=1 -> in_ready=16'h0020 in that cycle; next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_sel=5.
2. Direct mode, N=12, sel=13, in_valid=all ones -> in_ready=0 and out_valid stays 0 for all cycles.
3. Round-robin, in_valid=16'h8421 held, out_ready=1, rr_ptr=0 -> grant sequence 0,5,10,15,0,...; rr_ptr sequence 0,1,6,11,0.
4. Backpressure: fill output from ch3, hold out_ready=0 for 4 cycles with in_valid[3]=1 -> in_ready=0 throughout, out_data stable. Release out_ready -> back-to-back transfer with no bubble cycle.
5. Reset mid-operation: out_valid=1, rr_ptr=7, assert reset between clock edges -> out_valid=0, out_data=0, out_sel=0, rr_ptr=0 immediately without waiting for an edge. After release, the first round-robin grant starts its scan at index 0.
6. Mode switch: round-robin grants ch2 (rr_ptr becomes 3), switch to direct mode with sel=9 for 2 transfers, then back to round-robin with in_valid=all ones -> next grant is ch3.
